// File: rtl/pri_enc_pipe.sv
// pri_enc_pipe: parametrised two-stage lowest-index-first priority encoder
// with valid/ready handshake and optional rotating-start (wrap-around) search.
// Stage 1 reduces each GROUP-bit slice to (any, lowest-bit offset); stage 2
// picks the lowest active group and forms the absolute index.
module pri_enc_pipe #(
    parameter int WIDTH  = 96,
    parameter int GROUP  = 12,
    parameter int ROTATE = 0,
    parameter int IDX_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [IDX_W-1:0] start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] dout,
    output logic             found
);

    localparam int NGRP  = (WIDTH + GROUP - 1) / GROUP;
    localparam int PADW  = NGRP * GROUP;
    localparam int LOC_W = (GROUP > 1) ? $clog2(GROUP) : 1;

    typedef logic [NGRP-1:0][LOC_W-1:0] loc_vec_t;

    // Offset of the lowest set bit within one group (0 when the group is empty).
    function automatic logic [LOC_W-1:0] low_bit(input logic [GROUP-1:0] v);
        logic [LOC_W-1:0] loc;
        loc = '0;
        for (int unsigned b = GROUP; b > 0; b--) begin
            if (v[b-1]) loc = LOC_W'(b - 1);
        end
        return loc;
    endfunction

    // Absolute index from the lowest active group; WIDTH when no group is active.
    function automatic logic [IDX_W-1:0] pick(input logic [NGRP-1:0] any,
                                              input loc_vec_t        loc);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(WIDTH);
        for (int unsigned g = NGRP; g > 0; g--) begin
            if (any[g-1]) idx = IDX_W'((g - 1) * GROUP) + IDX_W'(loc[g-1]);
        end
        return idx;
    endfunction

    logic             adv;
    logic [IDX_W-1:0] start_eff;
    logic [PADW-1:0]  vec_u;
    logic [PADW-1:0]  vec_m;

    logic [NGRP-1:0]  any_m_d, any_u_d;
    loc_vec_t         loc_m_d, loc_u_d;

    logic             s1_valid_q;
    logic [NGRP-1:0]  any_m_q, any_u_q;
    loc_vec_t         loc_m_q, loc_u_q;

    logic             use_m;
    logic [IDX_W-1:0] dout_d;
    logic             found_d;

    logic             out_valid_q;
    logic [IDX_W-1:0] dout_q;
    logic             found_q;

    // Whole pipeline moves together; it only holds when a result is stuck at the output.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Build the zero-padded unmasked vector and the vector masked below the start index.
    // With ROTATE=0 (or an out-of-range start) the start is forced to 0, so m == u.
    always_comb begin
        start_eff = '0;
        if (ROTATE != 0 && start < IDX_W'(WIDTH)) start_eff = start;
        vec_u = '0;
        vec_u[WIDTH-1:0] = din;
        vec_m = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            vec_m[i] = din[i] & (IDX_W'(i) >= start_eff);
        end
    end

    // First-level reduction: per-group any flag and lowest-bit offset for both vectors.
    always_comb begin
        any_m_d = '0;
        any_u_d = '0;
        loc_m_d = '0;
        loc_u_d = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            any_m_d[g] = |vec_m[g*GROUP +: GROUP];
            any_u_d[g] = |vec_u[g*GROUP +: GROUP];
            loc_m_d[g] = low_bit(vec_m[g*GROUP +: GROUP]);
            loc_u_d[g] = low_bit(vec_u[g*GROUP +: GROUP]);
        end
    end

    // Stage 1 register: group summaries and valid, loaded whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            any_m_q    <= '0;
            any_u_q    <= '0;
            loc_m_q    <= '0;
            loc_u_q    <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            any_m_q    <= any_m_d;
            any_u_q    <= any_u_d;
            loc_m_q    <= loc_m_d;
            loc_u_q    <= loc_u_d;
        end
    end

    // Second-level select: masked result wins if it has any hit, otherwise wrap to unmasked.
    always_comb begin
        use_m   = |any_m_q;
        dout_d  = use_m ? pick(any_m_q, loc_m_q) : pick(any_u_q, loc_u_q);
        found_d = use_m | (|any_u_q);
    end

    // Stage 2 register: result and valid, held stable while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            found_q     <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            dout_q      <= dout_d;
            found_q     <= found_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign found     = found_q;

endmodule

// File: tb/tb_pri_enc_pipe.sv
// tb_pri_enc_pipe: scoreboard bench for pri_enc_pipe. Two 96-bit instances
// (plain and rotating) share one stimulus stream; a 20-bit/8-bit-group
// instance gets random traffic with random backpressure.
module tb_pri_enc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [95:0] din;
    logic [6:0]  start;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_found;
    logic [6:0]  a_dout;
    logic        r_in_ready, r_out_valid, r_found;
    logic [6:0]  r_dout;

    logic        n_in_valid;
    logic [19:0] n_din;
    logic [4:0]  n_start;
    logic        n_out_ready;
    logic        n_in_ready, n_out_valid, n_found;
    logic [4:0]  n_dout;

    pri_enc_pipe #(.WIDTH(96), .GROUP(12), .ROTATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .din(din), .start(start), .out_valid(a_out_valid), .out_ready(out_ready),
        .dout(a_dout), .found(a_found)
    );

    pri_enc_pipe #(.WIDTH(96), .GROUP(12), .ROTATE(1)) u_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
        .din(din), .start(start), .out_valid(r_out_valid), .out_ready(out_ready),
        .dout(r_dout), .found(r_found)
    );

    pri_enc_pipe #(.WIDTH(20), .GROUP(8), .ROTATE(0)) u_n (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .din(n_din), .start(n_start), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .dout(n_dout), .found(n_found)
    );

    int unsigned vecs = 0;
    int unsigned miscompares = 0;
    int unsigned a_q[$];
    int unsigned r_q[$];
    int unsigned n_q[$];
    int unsigned a_pops = 0, r_pops = 0, n_pops = 0;
    int unsigned a_e, r_e, n_e;
    bit          n_done = 1'b0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        vecs++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: scan from the effective start upward with wrap, first set bit wins.
    function automatic int unsigned ref_idx(input logic [95:0] d, input int unsigned st,
                                            input int unsigned w, input bit rot);
        int unsigned s;
        int unsigned i;
        s = (rot && st < w) ? st : 0;
        for (int unsigned k = 0; k < w; k++) begin
            i = (s + k) % w;
            if (d[i]) return i;
        end
        return w;
    endfunction

    function automatic logic [95:0] onehot(input int unsigned i);
        logic [95:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Present one item to the 96-bit pair starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [95:0] d, input logic [6:0] s);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        din      = d;
        start    = s;
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            if (a_in_ready) begin
                a_q.push_back(ref_idx(d, s, 96, 1'b0));
                if (r_in_ready) r_q.push_back(ref_idx(d, s, 96, 1'b1));
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("send_timeout", a_in_ready, 1);
    endtask

    task automatic n_send(input logic [19:0] d);
        bit done;
        done       = 1'b0;
        n_in_valid = 1'b1;
        n_din      = d;
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            if (n_in_ready) begin
                n_q.push_back(ref_idx({76'd0, d}, 0, 20, 1'b0));
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("n_send_timeout", n_in_ready, 1);
    endtask

    // Output monitors: a transfer is due at the next posedge, compare against queue head.
    always @(negedge clk) begin
        #2;
        if (a_out_valid === 1'b1 && out_ready) begin
            if (a_q.size() == 0) check("a_extra_output", a_q.size(), 1);
            else begin
                a_e = a_q.pop_front();
                check("a_dout", a_dout, a_e);
                check("a_found", a_found, a_e != 96);
                a_pops++;
            end
        end
        if (r_out_valid === 1'b1 && out_ready) begin
            if (r_q.size() == 0) check("r_extra_output", r_q.size(), 1);
            else begin
                r_e = r_q.pop_front();
                check("r_dout", r_dout, r_e);
                check("r_found", r_found, r_e != 96);
                r_pops++;
            end
        end
        if (n_out_valid === 1'b1 && n_out_ready) begin
            if (n_q.size() == 0) check("n_extra_output", n_q.size(), 1);
            else begin
                n_e = n_q.pop_front();
                check("n_dout", n_dout, n_e);
                check("n_found", n_found, n_e != 20);
                n_pops++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int unsigned base;
        logic [95:0] v;
        logic [19:0] nd;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        din         = '0;
        start       = '0;
        out_ready   = 1'b1;
        n_in_valid  = 1'b0;
        n_din       = '0;
        n_start     = '0;
        n_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_dout", a_dout, 0);
        check("rst_found", a_found, 0);
        check("rst_r_out_valid", r_out_valid, 0);
        check("rst_n_out_valid", n_out_valid, 0);
        check("rst_n_dout", n_dout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lowest bit wins; result appears two cycles after presentation.
        send(onehot(0) | onehot(95), 7'd0);
        in_valid = 1'b0;
        check("lat_cycle1", a_out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", a_out_valid, 1);
        check("lat_dout", a_dout, 0);
        repeat (2) @(negedge clk);

        // Back-to-back boundary patterns, one result per cycle.
        base = a_pops;
        send('0, 7'd0);
        send(onehot(95), 7'd0);
        send(onehot(12), 7'd0);
        send(onehot(11), 7'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #3;
        check("b2b_throughput", a_pops - base, 4);
        @(negedge clk);

        // Rotating start: hit at/after start, wrap past the top, out-of-range start, empty.
        v = onehot(5) | onehot(40);
        send(v, 7'd20);
        send(v, 7'd40);
        send(v, 7'd41);
        send(v, 7'd100);
        send('0, 7'd55);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Backpressure: A stalls at the output for three cycles, B and C must not be lost.
        send(onehot(3), 7'd0);
        send(onehot(50), 7'd0);
        out_ready = 1'b0;
        fork
            send(onehot(90), 7'd0);
            begin
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("stall_out_valid", a_out_valid, 1);
                    check("stall_dout", a_dout, 3);
                    check("stall_r_dout", r_dout, 3);
                    check("stall_in_ready", a_in_ready, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_a_drain", a_q.size(), 0);

        // Asynchronous reset with two items in flight discards both.
        send(onehot(7), 7'd0);
        send(onehot(8), 7'd0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        a_q.delete();
        r_q.delete();
        #1;
        check("async_rst_out_valid", a_out_valid, 0);
        check("async_rst_dout", a_dout, 0);
        check("async_rst_r_out_valid", r_out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", a_out_valid, 0);
            check("post_rst_r_out_valid", r_out_valid, 0);
        end

        // Padded geometry: random requests with random backpressure.
        fork
            begin
                while (!n_done) begin
                    @(negedge clk);
                    if (!n_done) n_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                n_in_valid = 1'b0;
                @(negedge clk);
            end
            nd = 20'($urandom) & (20'hFFFFF << $urandom_range(0, 20));
            n_send(nd);
        end
        n_in_valid  = 1'b0;
        n_done      = 1'b1;
        n_out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("n_drain", n_q.size(), 0);
        check("n_count", n_pops, 1000);
        check("a_drain", a_q.size(), 0);
        check("r_drain", r_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
